// File: rtl/wb_pkg.sv
// Shared widths and types for the register-file writeback arbiter.
package wb_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned REGIDX_W = 5;

  // One pending register-file write.
  typedef struct packed {
    logic [REGIDX_W-1:0] rd;
    logic [XLEN-1:0]     data;
  } wb_entry_t;

  // Which source owns the write port in a given cycle.
  typedef enum logic [1:0] {
    WB_SRC_NONE,
    WB_SRC_LOAD,
    WB_SRC_BUF,
    WB_SRC_ALU
  } wb_src_e;

  // x0 is hardwired to zero, so writes to it are dropped.
  function automatic logic rd_is_live(logic [REGIDX_W-1:0] rd);
    return rd != '0;
  endfunction

endpackage

// File: rtl/wb_skid_fifo.sv
// Small in-order buffer for ALU writes that lost arbitration.
// Shift-register organisation: slot 0 always holds the oldest entry, so the
// read-all view (present only with WB_FWD_EN) is already in age order.
module wb_skid_fifo
  import wb_pkg::*;
#(
  parameter int unsigned Depth = 2,
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,   // synchronous, active-low
  input  logic                  push_i,
  input  wb_entry_t             wdata_i,
  input  logic                  pop_i,
  output wb_entry_t             rdata_o,
  output logic                  full_o,
  output logic                  empty_o
`ifdef WB_FWD_EN
  ,
  output wb_entry_t [Depth-1:0] slots_o,
  output logic [CntW-1:0]       count_o
`endif
);

  wb_entry_t [Depth-1:0] mem_q, mem_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  do_push, do_pop;

  assign full_o  = cnt_q == CntW'(Depth);
  assign empty_o = cnt_q == '0;
  assign rdata_o = mem_q[0];
  assign do_pop  = pop_i && !empty_o;
  // A push into a full buffer is only legal when the head leaves in the same cycle.
  assign do_push = push_i && (!full_o || do_pop);

`ifdef WB_FWD_EN
  assign slots_o = mem_q;
  assign count_o = cnt_q;
`endif

  // Next-state: shift down on pop, then append at the first free slot on push.
  always_comb begin
    mem_d = mem_q;
    cnt_d = cnt_q;
    if (do_pop) begin
      for (int i = 0; i < int'(Depth) - 1; i++) begin
        mem_d[i] = mem_q[i+1];
      end
      cnt_d = cnt_d - CntW'(1);
    end
    if (do_push) begin
      for (int i = 0; i < int'(Depth); i++) begin
        if (cnt_d == CntW'(i)) begin
          mem_d[i] = wdata_i;
        end
      end
      cnt_d = cnt_d + CntW'(1);
    end
  end

  // Buffer state; reset discards anything still queued.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mem_q <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/writeback_arbiter.sv
// Register-file write-port arbiter: load responses win unconditionally, ALU
// results that lose are queued in order and drained ahead of newer ALU results.
// Data/index widths come from wb_pkg (XLEN, REGIDX_W).
// Optional feature macro WB_FWD_EN: adds a combinational decode bypass
// (fwd_rs/fwd_hit/fwd_data) looking into the buffer and the registered output.
module writeback_arbiter
  import wb_pkg::*;
#(
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                alu_valid,
  output logic                alu_ready,
  input  logic [REGIDX_W-1:0] alu_rd,
  input  logic [XLEN-1:0]     alu_data,
  input  logic                load_valid,
  input  logic [REGIDX_W-1:0] load_rd,
  input  logic [XLEN-1:0]     load_data,
  output logic                rf_we,
  output logic [REGIDX_W-1:0] rf_waddr,
  output logic [XLEN-1:0]     rf_wdata,
  output logic                wb_pending
`ifdef WB_FWD_EN
  ,
  input  logic [REGIDX_W-1:0] fwd_rs,
  output logic                fwd_hit,
  output logic [XLEN-1:0]     fwd_data
`endif
);

  localparam int unsigned CntW = $clog2(BUF_DEPTH + 1);

  wb_src_e             src;
  wb_entry_t           buf_head, alu_entry, wr_entry;
  logic                buf_full, buf_empty, buf_push, buf_pop;
  logic                alu_fire, wr_en;
  logic                rf_we_q;
  logic [REGIDX_W-1:0] rf_waddr_q;
  logic [XLEN-1:0]     rf_wdata_q;

`ifdef WB_FWD_EN
  wb_entry_t [BUF_DEPTH-1:0] buf_slots;
  logic [CntW-1:0]           buf_cnt;
`endif

  // Ready depends only on buffer occupancy, never on the valids.
  assign alu_ready  = rst_n && !buf_full;
  assign alu_fire   = alu_valid && alu_ready;
  assign alu_entry  = '{rd: alu_rd, data: alu_data};
  assign wb_pending = !buf_empty;

  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;

  // Pick the port owner and decide what enters or leaves the buffer.
  always_comb begin
    src      = WB_SRC_NONE;
    wr_entry = '0;
    if (load_valid) begin
      src = WB_SRC_LOAD;
    end else if (!buf_empty) begin
      src = WB_SRC_BUF;
    end else if (alu_fire) begin
      src = WB_SRC_ALU;
    end

    unique case (src)
      WB_SRC_LOAD: wr_entry = '{rd: load_rd, data: load_data};
      WB_SRC_BUF:  wr_entry = buf_head;
      WB_SRC_ALU:  wr_entry = alu_entry;
      default:     wr_entry = '0;
    endcase

    // A slot taken by an x0 load is still consumed: it is simply not written.
    wr_en    = (src != WB_SRC_NONE) && rd_is_live(wr_entry.rd);
    buf_pop  = src == WB_SRC_BUF;
    buf_push = alu_fire && rd_is_live(alu_rd) && (src != WB_SRC_ALU);
  end

  wb_skid_fifo #(
    .Depth (BUF_DEPTH)
  ) u_skid_fifo (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .push_i  (buf_push),
    .wdata_i (alu_entry),
    .pop_i   (buf_pop),
    .rdata_o (buf_head),
    .full_o  (buf_full),
    .empty_o (buf_empty)
`ifdef WB_FWD_EN
    ,
    .slots_o (buf_slots),
    .count_o (buf_cnt)
`endif
  );

  // Registered write port; address/data hold when no write happens.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      rf_we_q <= wr_en;
      if (wr_en) begin
        rf_waddr_q <= wr_entry.rd;
        rf_wdata_q <= wr_entry.data;
      end
    end
  end

`ifdef WB_FWD_EN
  // Bypass lookup: youngest buffered match wins, else the write in flight.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    if (fwd_rs != '0) begin
      if (rf_we_q && (rf_waddr_q == fwd_rs)) begin
        fwd_hit  = 1'b1;
        fwd_data = rf_wdata_q;
      end
      // Later slots are younger, so later matches override earlier ones.
      for (int i = 0; i < int'(BUF_DEPTH); i++) begin
        if ((CntW'(i) < buf_cnt) && (buf_slots[i].rd == fwd_rs)) begin
          fwd_hit  = 1'b1;
          fwd_data = buf_slots[i].data;
        end
      end
    end
  end
`endif

endmodule
